// File: rtl/bram_port_arbiter_pkg.sv
// Shared helpers for the BRAM port arbiter: requester-id width and its typedef.
package bram_arbiter_pkg;

    // Width of a requester index; a single requester still gets a 1-bit id.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : unsigned'($clog2(n));
    endfunction

    localparam int unsigned DefNumReq   = 2;
    localparam int unsigned RespIdWidth = clog2_min1(DefNumReq);

    typedef logic [RespIdWidth-1:0] resp_id_t;

endpackage

// File: rtl/bram_port_arbiter_if.sv
// Requester request/response channels plus the shared BRAM port pins.
interface bram_port_arbiter_if #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 64
);
    logic [NUM_REQ-1:0]              req_valid;
    logic [NUM_REQ-1:0]              req_ready;
    logic [NUM_REQ*DATA_WIDTH/8-1:0] req_we;
    logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr;
    logic [NUM_REQ*DATA_WIDTH-1:0]   req_wrdata;
    logic [NUM_REQ-1:0]              resp_valid;
    logic [NUM_REQ-1:0]              resp_ready;
    logic [DATA_WIDTH-1:0]           resp_rddata;

    logic                            mem_en;
    logic [DATA_WIDTH/8-1:0]         mem_we;
    logic [ADDR_WIDTH-1:0]           mem_addr;
    logic [DATA_WIDTH-1:0]           mem_wrdata;
    logic [DATA_WIDTH-1:0]           mem_rddata;

    // Arbiter side
    modport slave (
        input  req_valid, req_we, req_addr, req_wrdata, resp_ready, mem_rddata,
        output req_ready, resp_valid, resp_rddata, mem_en, mem_we, mem_addr, mem_wrdata
    );

    // Requester / memory side
    modport master (
        output req_valid, req_we, req_addr, req_wrdata, resp_ready, mem_rddata,
        input  req_ready, resp_valid, resp_rddata, mem_en, mem_we, mem_addr, mem_wrdata
    );

endinterface

// File: rtl/bram_port_arbiter_rr.sv
// Combinational round-robin grant: first requester at or after ptr, wrapping modulo N.
module round_robin_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]                req,
    input  logic                        en,
    input  logic [clog2_min1(N)-1:0]    ptr,
    output logic [N-1:0]                gnt
);
    localparam int unsigned PtrW = clog2_min1(N);

    logic [PtrW-1:0] idx;
    logic            found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = PtrW'((32'(ptr) + k) % N);
            if (en && !found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port among NUM_REQ requesters; backpressure stalls the port instead of buffering.
module bram_port_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 64
) (
    input logic               clk,
    input logic               rstn,
    bram_port_arbiter_if.slave bus
);
    localparam int unsigned IdW = clog2_min1(NUM_REQ);
    localparam int unsigned BeW = DATA_WIDTH / 8;

    logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
    logic [IdW-1:0]     resp_id_q, resp_id_d;
    logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] gnt;
    logic [IdW-1:0]     gnt_idx;
    logic [IdW-1:0]     sel;
    logic               gnt_any;
    logic               resp_pending;
    logic               resp_taken;
    logic               can_issue;

    assign resp_pending = |resp_valid_q;
    assign resp_taken   = resp_pending && bus.resp_ready[resp_id_q];
    // Holding mem_en low while stalled keeps mem_rddata (and thus resp_rddata) frozen.
    assign can_issue    = !resp_pending || resp_taken;

    round_robin_arbiter #(
        .N (NUM_REQ)
    ) u_rr (
        .req (bus.req_valid),
        .en  (can_issue),
        .ptr (rr_ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) gnt_idx = IdW'(i);
        end
    end

    assign gnt_any = |gnt;
    assign sel     = gnt_any ? gnt_idx : rr_ptr_q;

    assign bus.req_ready   = gnt;
    assign bus.mem_en      = gnt_any;
    assign bus.mem_we      = gnt_any ? bus.req_we[sel*BeW +: BeW] : '0;
    assign bus.mem_addr    = bus.req_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
    assign bus.mem_wrdata  = bus.req_wrdata[sel*DATA_WIDTH +: DATA_WIDTH];
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_rddata = bus.mem_rddata;

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        rr_ptr_d     = rr_ptr_q;
        if (gnt_any) begin
            resp_valid_d = gnt;
            resp_id_d    = gnt_idx;
            rr_ptr_d     = (gnt_idx == IdW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end else if (resp_taken) begin
            resp_valid_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_valid_q <= '0;
            resp_id_q    <= '0;
            rr_ptr_q     <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: directed vector table (2 requesters) plus random traffic (3 requesters).
module tb_bram_port_arbiter;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    bram_port_arbiter_if #(.NUM_REQ(2), .ADDR_WIDTH(16), .DATA_WIDTH(64)) bus2 ();
    bram_port_arbiter_if #(.NUM_REQ(3), .ADDR_WIDTH(16), .DATA_WIDTH(64)) bus3 ();

    bram_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(16), .DATA_WIDTH(64)) u_dut2 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus2)
    );

    bram_port_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(16), .DATA_WIDTH(64)) u_dut3 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus3)
    );

    function automatic logic [63:0] init_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        return (i == 5) ? 64'h0 : {8'hA5, 48'h0, b};
    endfunction

    // Read-first BRAM models with byte enables; contents reload while reset spans an edge.
    logic [63:0] mem2 [256];
    logic [63:0] mem3 [256];

    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 256; i++) mem2[i] <= init_word(i);
            bus2.mem_rddata <= '0;
        end else if (bus2.mem_en) begin
            bus2.mem_rddata <= mem2[bus2.mem_addr[7:0]];
            for (int b = 0; b < 8; b++)
                if (bus2.mem_we[b]) mem2[bus2.mem_addr[7:0]][b*8 +: 8] <= bus2.mem_wrdata[b*8 +: 8];
        end
    end

    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 256; i++) mem3[i] <= init_word(i);
            bus3.mem_rddata <= '0;
        end else if (bus3.mem_en) begin
            bus3.mem_rddata <= mem3[bus3.mem_addr[7:0]];
            for (int b = 0; b < 8; b++)
                if (bus3.mem_we[b]) mem3[bus3.mem_addr[7:0]][b*8 +: 8] <= bus3.mem_wrdata[b*8 +: 8];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [7:0]  we0;
        logic [15:0] addr0;
        logic [15:0] addr1;
        logic [1:0]  rready;
        logic [1:0]  exp_ready;
        logic        exp_en;
        logic [15:0] exp_addr;
        logic [7:0]  exp_we;
        logic [1:0]  exp_rvalid;
        logic        chk_data;
        logic [63:0] exp_data;
    } vec_t;

    localparam logic [63:0] W10 = 64'hA500_0000_0000_0010;
    localparam logic [63:0] W20 = 64'hA500_0000_0000_0020;
    localparam logic [63:0] W30 = 64'hA500_0000_0000_0030;
    localparam logic [63:0] W40 = 64'hA500_0000_0000_0040;
    localparam logic [63:0] WD0 = 64'h1122_3344_5566_7788;
    localparam logic [63:0] WD1 = 64'hDEAD_BEEF_0BAD_F00D;

    vec_t        vecs [14];
    logic [2:0]  fair_exp [7];
    logic [63:0] gold3 [256];

    // Reference model state for the 3-requester random run
    int          ptr;
    int          g;
    bit          pend;
    int          pend_id;
    logic [63:0] pend_data;
    logic [2:0]  v, rr, exp_rdy;
    logic [7:0]  we [3];
    logic [15:0] ad [3];
    logic [63:0] wd [3];

    initial begin
        bus2.req_valid  = '0;
        bus2.req_we     = '0;
        bus2.req_addr   = '0;
        bus2.req_wrdata = {WD1, WD0};
        bus2.resp_ready = '0;
        bus3.req_valid  = '0;
        bus3.req_we     = '0;
        bus3.req_addr   = '0;
        bus3.req_wrdata = '0;
        bus3.resp_ready = '0;

        //        valid  we0    addr0     addr1     rrdy   ready  en    addr      we     rvld   chk   data
        vecs[0]  = '{2'b01, 8'h00, 16'h0010, 16'h0000, 2'b11, 2'b01, 1'b1, 16'h0010, 8'h00, 2'b00, 1'b0, 64'h0};
        vecs[1]  = '{2'b00, 8'h00, 16'h0010, 16'h0000, 2'b11, 2'b00, 1'b0, 16'h0000, 8'h00, 2'b01, 1'b1, W10};
        vecs[2]  = '{2'b01, 8'h0F, 16'h0005, 16'h0000, 2'b11, 2'b01, 1'b1, 16'h0005, 8'h0F, 2'b00, 1'b0, 64'h0};
        vecs[3]  = '{2'b01, 8'h00, 16'h0005, 16'h0000, 2'b11, 2'b01, 1'b1, 16'h0005, 8'h00, 2'b01, 1'b1, 64'h0};
        vecs[4]  = '{2'b00, 8'h00, 16'h0005, 16'h0000, 2'b11, 2'b00, 1'b0, 16'h0000, 8'h00, 2'b01, 1'b1,
                     64'h0000_0000_5566_7788};
        vecs[5]  = '{2'b11, 8'h00, 16'h0020, 16'h0030, 2'b11, 2'b10, 1'b1, 16'h0030, 8'h00, 2'b00, 1'b0, 64'h0};
        vecs[6]  = '{2'b11, 8'h00, 16'h0020, 16'h0030, 2'b11, 2'b01, 1'b1, 16'h0020, 8'h00, 2'b10, 1'b1, W30};
        vecs[7]  = '{2'b11, 8'h00, 16'h0020, 16'h0030, 2'b11, 2'b10, 1'b1, 16'h0030, 8'h00, 2'b01, 1'b1, W20};
        vecs[8]  = '{2'b10, 8'h00, 16'h0020, 16'h0030, 2'b11, 2'b10, 1'b1, 16'h0030, 8'h00, 2'b10, 1'b1, W30};
        vecs[9]  = '{2'b01, 8'h00, 16'h0020, 16'h0030, 2'b01, 2'b00, 1'b0, 16'h0000, 8'h00, 2'b10, 1'b1, W30};
        vecs[10] = '{2'b01, 8'h00, 16'h0020, 16'h0030, 2'b01, 2'b00, 1'b0, 16'h0000, 8'h00, 2'b10, 1'b1, W30};
        vecs[11] = '{2'b01, 8'h00, 16'h0020, 16'h0030, 2'b01, 2'b00, 1'b0, 16'h0000, 8'h00, 2'b10, 1'b1, W30};
        vecs[12] = '{2'b01, 8'h00, 16'h0020, 16'h0030, 2'b11, 2'b01, 1'b1, 16'h0020, 8'h00, 2'b10, 1'b1, W30};
        vecs[13] = '{2'b00, 8'h00, 16'h0020, 16'h0030, 2'b11, 2'b00, 1'b0, 16'h0000, 8'h00, 2'b01, 1'b1, W20};

        fair_exp[0] = 3'b001; fair_exp[1] = 3'b010; fair_exp[2] = 3'b100; fair_exp[3] = 3'b001;
        fair_exp[4] = 3'b100; fair_exp[5] = 3'b001; fair_exp[6] = 3'b100;

        for (int i = 0; i < 256; i++) gold3[i] = init_word(i);

        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check("reset resp_valid2", 64'(bus2.resp_valid), 64'h0);
        check("reset req_ready2", 64'(bus2.req_ready), 64'h0);
        check("reset mem_en2", 64'(bus2.mem_en), 64'h0);
        check("reset resp_valid3", 64'(bus3.resp_valid), 64'h0);

        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            bus2.req_valid        = vecs[i].valid;
            bus2.req_we           = {8'h00, vecs[i].we0};
            bus2.req_addr         = {vecs[i].addr1, vecs[i].addr0};
            bus2.resp_ready       = vecs[i].rready;
            @(negedge clk);
            check($sformatf("vec%0d req_ready", i), 64'(bus2.req_ready), 64'(vecs[i].exp_ready));
            check($sformatf("vec%0d mem_en", i), 64'(bus2.mem_en), 64'(vecs[i].exp_en));
            check($sformatf("vec%0d mem_we", i), 64'(bus2.mem_we), 64'(vecs[i].exp_we));
            if (vecs[i].exp_en)
                check($sformatf("vec%0d mem_addr", i), 64'(bus2.mem_addr), 64'(vecs[i].exp_addr));
            check($sformatf("vec%0d resp_valid", i), 64'(bus2.resp_valid), 64'(vecs[i].exp_rvalid));
            if (vecs[i].chk_data)
                check($sformatf("vec%0d resp_rddata", i), bus2.resp_rddata, vecs[i].exp_data);
        end

        // Async reset while requester 1's response is outstanding
        @(posedge clk);
        #1;
        bus2.req_valid  = 2'b10;
        bus2.req_addr   = {16'h0040, 16'h0000};
        bus2.resp_ready = 2'b00;
        @(negedge clk);
        check("midrst grant1", 64'(bus2.req_ready), 64'h2);
        @(posedge clk);
        #1 bus2.req_valid = 2'b00;
        @(negedge clk);
        check("midrst pending", 64'(bus2.resp_valid), 64'h2);
        check("midrst data", bus2.resp_rddata, W40);
        #2 rstn = 1'b0;
        #1;
        check("midrst resp_valid cleared", 64'(bus2.resp_valid), 64'h0);
        check("midrst mem_en", 64'(bus2.mem_en), 64'h0);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        bus2.req_valid  = 2'b11;
        bus2.resp_ready = 2'b11;
        @(negedge clk);
        check("midrst first grant", 64'(bus2.req_ready), 64'h1);
        @(posedge clk);
        #1 bus2.req_valid = 2'b00;

        // Random traffic on the 3-requester instance, checked against a transaction model
        ptr  = 0;
        pend = 1'b0;
        pend_id = 0;
        pend_data = '0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                v[i]  = 1'($urandom_range(0, 1));
                we[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
                ad[i] = 16'($urandom_range(0, 15));
                wd[i] = {$urandom, $urandom};
                rr[i] = ($urandom_range(0, 3) != 0);
                bus3.req_we[i*8 +: 8]      = we[i];
                bus3.req_addr[i*16 +: 16]  = ad[i];
                bus3.req_wrdata[i*64 +: 64] = wd[i];
            end
            bus3.req_valid  = v;
            bus3.resp_ready = rr;
            @(negedge clk);
            g = -1;
            if (!pend || rr[pend_id]) begin
                for (int k = 0; k < 3; k++) begin
                    int i;
                    i = (ptr + k) % 3;
                    if (g < 0 && v[i]) g = i;
                end
            end
            exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
            check("rnd req_ready", 64'(bus3.req_ready), 64'(exp_rdy));
            check("rnd resp_valid", 64'(bus3.resp_valid), pend ? 64'(1 << pend_id) : 64'h0);
            if (pend) check("rnd resp_rddata", bus3.resp_rddata, pend_data);
            check("rnd mem_en", 64'(bus3.mem_en), (g >= 0) ? 64'h1 : 64'h0);
            if (g >= 0) begin
                check("rnd mem_addr", 64'(bus3.mem_addr), 64'(ad[g]));
                check("rnd mem_we", 64'(bus3.mem_we), 64'(we[g]));
                check("rnd mem_wrdata", bus3.mem_wrdata, wd[g]);
                pend_data = gold3[ad[g][7:0]];
                for (int b = 0; b < 8; b++)
                    if (we[g][b]) gold3[ad[g][7:0]][b*8 +: 8] = wd[g][b*8 +: 8];
                pend    = 1'b1;
                pend_id = g;
                ptr     = (g + 1) % 3;
            end else begin
                check("rnd mem_we idle", 64'(bus3.mem_we), 64'h0);
                if (pend && rr[pend_id]) pend = 1'b0;
            end
        end

        // Reset mid-cycle, then check the 3-way rotation restarts at requester 0
        bus3.req_valid  = 3'b000;
        bus3.resp_ready = 3'b111;
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        check("rst3 resp_valid", 64'(bus3.resp_valid), 64'h0);
        @(posedge clk);
        #1 rstn = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(posedge clk);
            #1 bus3.req_valid = (c < 4) ? 3'b111 : 3'b101;
            @(negedge clk);
            check($sformatf("fair%0d grant", c), 64'(bus3.req_ready), 64'(fair_exp[c]));
        end
        @(posedge clk);
        #1 bus3.req_valid = 3'b000;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
